// File: rtl/alarm_controller_pkg.sv
// Shared types and time-of-day limits for the alarm controller.
// The state encoding is visible on the state port, so the values are fixed.
package alarm_controller_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } alarm_state_e;

    localparam int MAX_SEC      = 59;
    localparam int MAX_MIN      = 59;
    localparam int MAX_HOUR     = 23;
    localparam int SECS_PER_MIN = 60;

    // Increment a time field, wrapping to zero past its maximum.
    function automatic logic [5:0] wrap_inc(input logic [5:0] value, input logic [5:0] max_value);
        return (value == max_value) ? 6'd0 : value + 6'd1;
    endfunction

endpackage

// File: rtl/alarm_controller_sec_tick_detect.sv
// Turns changes of the incoming seconds value into one-cycle tick pulses,
// so the alarm logic runs entirely on the system clock.
module sec_tick_detect (
    input  logic       clk,
    input  logic       clear,
    input  logic [5:0] sec,
    output logic       sec_tick
);

    logic [5:0] sec_prev_q;
    logic [5:0] sec_prev_d;

    always_comb begin
        sec_prev_d = sec;
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            sec_prev_q <= 6'd0;
        end else begin
            sec_prev_q <= sec_prev_d;
        end
    end

    assign sec_tick = (sec != sec_prev_q);

endmodule

// File: rtl/alarm_controller.sv
// Alarm clock controller: user-editable alarm time, ring/snooze/stop FSM
// driven by second ticks derived from the live time-of-day counter.
module alarm_controller
    import alarm_controller_pkg::*;
#(
    parameter int RING_SECS    = 30,
    parameter int SNOOZE_MINS  = 5,
    parameter int DEFAULT_MIN  = 0,
    parameter int DEFAULT_HOUR = 7
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [5:0] hour,
    input  logic       alarm_en,
    input  logic       alarm_set,
    input  logic       adj_min,
    input  logic       adj_hour,
    input  logic       snooze,
    input  logic       stop,
    output logic [5:0] alarm_min,
    output logic [5:0] alarm_hour,
    output logic       ringing,
    output logic [1:0] state
);

    localparam int SNZ_W = $clog2(SNOOZE_MINS * SECS_PER_MIN);
    localparam logic [5:0]       RING_LAST = 6'(RING_SECS - 1);
    localparam logic [SNZ_W-1:0] SNZ_LAST  = SNZ_W'(SNOOZE_MINS * SECS_PER_MIN - 1);

    logic             sec_tick;
    logic             trigger;
    alarm_state_e     state_q, state_d;
    logic [5:0]       alarm_min_q, alarm_min_d;
    logic [5:0]       alarm_hour_q, alarm_hour_d;
    logic [5:0]       ring_cnt_q, ring_cnt_d;
    logic [SNZ_W-1:0] snz_cnt_q, snz_cnt_d;
    logic             ringing_q, ringing_d;

    sec_tick_detect u_sec_tick (
        .clk      (clk),
        .clear    (clear),
        .sec      (sec),
        .sec_tick (sec_tick)
    );

    always_comb begin
        alarm_min_d  = alarm_min_q;
        alarm_hour_d = alarm_hour_q;
        if (alarm_set) begin
            if (adj_min) begin
                alarm_min_d = wrap_inc(alarm_min_q, 6'(MAX_MIN));
            end
            if (adj_hour) begin
                alarm_hour_d = wrap_inc(alarm_hour_q, 6'(MAX_HOUR));
            end
        end
    end

    // Requiring a tick on sec==0 limits triggering to once per minute boundary.
    assign trigger = alarm_en && !alarm_set && sec_tick && (sec == 6'd0) &&
                     (min == alarm_min_q) && (hour == alarm_hour_q);

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        if (!alarm_en || alarm_set) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        state_d    = RINGING;
                        ring_cnt_d = 6'd0;
                    end
                end
                RINGING: begin
                    if (stop) begin
                        state_d = IDLE;
                    end else if (snooze) begin
                        state_d   = SNOOZE;
                        snz_cnt_d = '0;
                    end else if (sec_tick) begin
                        if (ring_cnt_q == RING_LAST) begin
                            state_d = IDLE;
                        end else begin
                            ring_cnt_d = ring_cnt_q + 6'd1;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop) begin
                        state_d = IDLE;
                    end else if (sec_tick) begin
                        if (snz_cnt_q == SNZ_LAST) begin
                            state_d    = RINGING;
                            ring_cnt_d = 6'd0;
                        end else begin
                            snz_cnt_d = snz_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        ringing_d = (state_d == RINGING);
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q      <= IDLE;
            alarm_min_q  <= 6'(DEFAULT_MIN);
            alarm_hour_q <= 6'(DEFAULT_HOUR);
            ring_cnt_q   <= 6'd0;
            snz_cnt_q    <= '0;
            ringing_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            alarm_min_q  <= alarm_min_d;
            alarm_hour_q <= alarm_hour_d;
            ring_cnt_q   <= ring_cnt_d;
            snz_cnt_q    <= snz_cnt_d;
            ringing_q    <= ringing_d;
        end
    end

    assign alarm_min  = alarm_min_q;
    assign alarm_hour = alarm_hour_q;
    assign ringing    = ringing_q;
    assign state      = state_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed plus randomized bench for alarm_controller, checked against a
// seconds-remaining reference model of the alarm's behaviour.
module tb_alarm_controller;

    localparam int RING_SECS   = 30;
    localparam int SNOOZE_MINS = 5;

    logic       clk = 1'b0;
    logic       clear;
    logic [5:0] sec, min, hour;
    logic       alarm_en, alarm_set, adj_min, adj_hour, snooze, stop;
    logic [5:0] alarm_min, alarm_hour;
    logic       ringing;
    logic [1:0] state;

    int nVectors     = 0;
    int nMiscompares = 0;

    int tSec, tMin, tHour;
    bit tEn, tSet;

    // Reference model: 0 idle, 1 ringing, 2 snoozing; countdowns in seconds left.
    int mState, mMin, mHour, mPrev, ringLeft, snoozeLeft;

    always #5 clk = ~clk;

    alarm_controller #(
        .RING_SECS    (RING_SECS),
        .SNOOZE_MINS  (SNOOZE_MINS),
        .DEFAULT_MIN  (0),
        .DEFAULT_HOUR (7)
    ) dut (
        .clk        (clk),
        .clear      (clear),
        .sec        (sec),
        .min        (min),
        .hour       (hour),
        .alarm_en   (alarm_en),
        .alarm_set  (alarm_set),
        .adj_min    (adj_min),
        .adj_hour   (adj_hour),
        .snooze     (snooze),
        .stop       (stop),
        .alarm_min  (alarm_min),
        .alarm_hour (alarm_hour),
        .ringing    (ringing),
        .state      (state)
    );

    task automatic modelReset();
        mState = 0; mMin = 0; mHour = 7; mPrev = 0; ringLeft = 0; snoozeLeft = 0;
    endtask

    task automatic modelStep();
        bit tick, hit;
        tick  = (tSec != mPrev);
        mPrev = tSec;
        hit   = tick && tSec == 0 && tMin == mMin && tHour == mHour;
        if (tSet) begin
            if (adj_min)  mMin  = (mMin + 1) % 60;
            if (adj_hour) mHour = (mHour + 1) % 24;
        end
        if (!tEn || tSet) begin
            mState = 0;
        end else if (mState == 0) begin
            if (hit) begin mState = 1; ringLeft = RING_SECS; end
        end else if (mState == 1) begin
            if (stop) mState = 0;
            else if (snooze) begin mState = 2; snoozeLeft = SNOOZE_MINS * 60; end
            else if (tick) begin
                ringLeft--;
                if (ringLeft == 0) mState = 0;
            end
        end else begin
            if (stop) mState = 0;
            else if (tick) begin
                snoozeLeft--;
                if (snoozeLeft == 0) begin mState = 1; ringLeft = RING_SECS; end
            end
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVectors++;
        assert (got === exp) else begin
            nMiscompares++;
            $error("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".ringing"},    32'(ringing),    32'(mState == 1));
        checkValue({tag, ".state"},      32'(state),      32'(mState));
        checkValue({tag, ".alarm_min"},  32'(alarm_min),  32'(mMin));
        checkValue({tag, ".alarm_hour"}, 32'(alarm_hour), 32'(mHour));
    endtask

    // Drives one clock cycle with the current time/levels and the given pulses.
    task automatic applyStimulus(input bit am, input bit ah, input bit sn, input bit st, input string tag);
        sec = 6'(tSec); min = 6'(tMin); hour = 6'(tHour);
        alarm_en = tEn; alarm_set = tSet;
        adj_min = am; adj_hour = ah; snooze = sn; stop = st;
        modelStep();
        @(posedge clk);
        #1;
        adj_min = 1'b0; adj_hour = 1'b0; snooze = 1'b0; stop = 1'b0;
        checkOutput(tag);
    endtask

    initial begin
        tSec = 0; tMin = 0; tHour = 0; tEn = 0; tSet = 0;
        sec = '0; min = '0; hour = '0;
        alarm_en = 0; alarm_set = 0; adj_min = 0; adj_hour = 0; snooze = 0; stop = 0;
        clear = 1'b1;
        modelReset();
        #12;
        checkValue("reset.alarm_min", 32'(alarm_min), 0);
        checkValue("reset.alarm_hour", 32'(alarm_hour), 7);
        checkValue("reset.ringing", 32'(ringing), 0);
        checkValue("reset.state", 32'(state), 0);
        @(posedge clk); #1;
        clear = 1'b0;

        applyStimulus(1, 0, 0, 0, "adj_locked");
        checkValue("adj_locked.const", 32'(alarm_min), 0);

        tSet = 1;
        for (int i = 0; i < 60; i++) applyStimulus(1, 0, 0, 0, "edit_min");
        checkValue("edit_min.wrap", 32'(alarm_min), 0);
        for (int i = 0; i < 24; i++) applyStimulus(0, 1, 0, 0, "edit_hour");
        checkValue("edit_hour.wrap", 32'(alarm_hour), 7);
        applyStimulus(1, 1, 0, 0, "edit_both");
        checkValue("edit_both.min", 32'(alarm_min), 1);
        checkValue("edit_both.hour", 32'(alarm_hour), 8);
        for (int i = 0; i < 59; i++) applyStimulus(1, 0, 0, 0, "restore_min");
        for (int i = 0; i < 23; i++) applyStimulus(0, 1, 0, 0, "restore_hour");
        checkValue("restore.min", 32'(alarm_min), 0);
        checkValue("restore.hour", 32'(alarm_hour), 7);

        tSet = 0; tEn = 1;
        tHour = 6; tMin = 59; tSec = 59;
        applyStimulus(0, 0, 0, 0, "pre_alarm");
        applyStimulus(0, 0, 0, 0, "pre_alarm");
        tHour = 7; tMin = 0; tSec = 0;
        applyStimulus(0, 0, 0, 0, "trigger");
        checkValue("trigger.ringing", 32'(ringing), 1);
        for (int k = 1; k <= RING_SECS; k++) begin
            tSec = k;
            applyStimulus(0, 0, 0, 0, "ring_timeout");
            if (k == RING_SECS - 1) checkValue("ring_last_sec", 32'(ringing), 1);
            if (k == RING_SECS) checkValue("ring_expired", 32'(state), 0);
        end

        tSec = 0;
        applyStimulus(0, 0, 0, 0, "retrigger");
        checkValue("retrigger.ringing", 32'(ringing), 1);
        applyStimulus(0, 0, 0, 1, "stop");
        checkValue("stop.state", 32'(state), 0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, 0, 0, "hold_sec0");
            checkValue("hold_sec0.ringing", 32'(ringing), 0);
        end

        tSec = 59; applyStimulus(0, 0, 0, 0, "pre_snooze");
        tSec = 0;  applyStimulus(0, 0, 0, 0, "ring_for_snooze");
        applyStimulus(0, 0, 1, 0, "snooze");
        checkValue("snooze.state", 32'(state), 2);
        tMin = 30;
        for (int i = 1; i <= SNOOZE_MINS * 60; i++) begin
            tSec = (tSec + 1) % 60;
            applyStimulus(0, 0, 0, 0, "snooze_wait");
            if (i == SNOOZE_MINS * 60 - 1) checkValue("snooze_last_tick", 32'(ringing), 0);
            if (i == SNOOZE_MINS * 60) checkValue("snooze_expired", 32'(ringing), 1);
        end

        applyStimulus(0, 0, 1, 1, "stop_beats_snooze");
        checkValue("stop_beats_snooze.state", 32'(state), 0);

        tMin = 0; tSec = 59; applyStimulus(0, 0, 0, 0, "pre_en_drop");
        tSec = 0; applyStimulus(0, 0, 0, 0, "ring_en_drop");
        applyStimulus(0, 0, 1, 0, "snooze_en_drop");
        tEn = 0; applyStimulus(0, 0, 0, 0, "en_drop");
        checkValue("en_drop.state", 32'(state), 0);
        tEn = 1;

        tSet = 1;
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, "set_0705");
        tSet = 0; tMin = 5; tSec = 59;
        applyStimulus(0, 0, 0, 0, "pre_clear");
        tSec = 0;
        applyStimulus(0, 0, 0, 0, "ring_0705");
        checkValue("ring_0705.ringing", 32'(ringing), 1);
        clear = 1'b1;
        modelReset();
        #2;
        checkValue("async_clear.ringing", 32'(ringing), 0);
        checkValue("async_clear.state", 32'(state), 0);
        checkValue("async_clear.alarm_min", 32'(alarm_min), 0);
        checkValue("async_clear.alarm_hour", 32'(alarm_hour), 7);
        @(posedge clk); #1;
        clear = 1'b0;

        for (int i = 0; i < 600; i++) begin
            int r;
            bit am, ah, sn, st;
            tEn  = ($urandom_range(0, 19) != 0);
            tSet = ($urandom_range(0, 29) == 0);
            r = $urandom_range(0, 7);
            if (r < 3) tSec = tSec;
            else if (r < 6) tSec = (tSec + 1) % 60;
            else if (r == 6) tSec = 0;
            else tSec = $urandom_range(0, 59);
            tMin  = ($urandom_range(0, 1) != 0) ? mMin  : $urandom_range(0, 63);
            tHour = ($urandom_range(0, 3) != 0) ? mHour : $urandom_range(0, 63);
            am = ($urandom_range(0, 7) == 0);
            ah = ($urandom_range(0, 7) == 0);
            sn = ($urandom_range(0, 15) == 0);
            st = ($urandom_range(0, 23) == 0);
            applyStimulus(am, ah, sn, st, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Downstream consumer of the time-of-day counter chain; watches the live sec/min/hour values and owns a user-settable alarm time.
- Raises a ringing output at the programmed time for a bounded number of seconds, with snooze and stop handling.
- Second ticks are derived internally by detecting changes of the incoming sec value, so the block runs on the single system clock.

Parameters:
- RING_SECS, 30, seconds the alarm rings before auto-stop (1..59)
- SNOOZE_MINS, 5, snooze length in minutes (1..9)
- DEFAULT_MIN, 0, alarm minute loaded at reset (0..59)
- DEFAULT_HOUR, 7, alarm hour loaded at reset (0..23)

Ports:
- clk  in  1  system clock, rising edge
- clear  in  1  asynchronous active-high reset
- sec  in  6  current seconds 0..59, from time counter
- min  in  6  current minutes 0..59
- hour  in  6  current hours 0..23
- alarm_en  in  1  level; alarm armed when high
- alarm_set  in  1  level; edit mode for alarm time
- adj_min  in  1  one-cycle pulse; increment alarm minute (edit mode only)
- adj_hour  in  1  one-cycle pulse; increment alarm hour (edit mode only)
- snooze  in  1  one-cycle pulse
- stop  in  1  one-cycle pulse
- alarm_min  out  6  programmed alarm minute
- alarm_hour  out  6  programmed alarm hour
- ringing  out  1  registered; high while state is RINGING
- state  out  2  current FSM state encoding

Behaviour:
- Reset (async, clear=1):
  - alarm_min=DEFAULT_MIN, alarm_hour=DEFAULT_HOUR.
  - state=IDLE, ringing=0, ring and snooze counters=0, sec_prev=0.
- Tick: sec_tick=1 on a cycle where sec != sec_prev. sec_prev updates every cycle.
- Editing:
  - Applies only while alarm_set=1.
  - adj_min increments alarm_min, wrapping 59->0. adj_hour increments alarm_hour, wrapping 23->0.
  - Both pulses in the same cycle update both fields independently.
  - Pulses are ignored when alarm_set=0. The new value is visible on the next cycle.
- Trigger condition: state=IDLE & alarm_en & !alarm_set & sec_tick & sec==0 & min==alarm_min & hour==alarm_hour. This gives at most one trigger per minute boundary.
- FSM states: IDLE=0, RINGING=1, SNOOZE=2; encoding 3 is unused and recovers to IDLE.
  - IDLE -> RINGING on trigger; ring_cnt cleared.
  - RINGING: ring_cnt++ on each sec_tick. At ring_cnt==RING_SECS-1 plus a tick -> IDLE.
  - RINGING -> SNOOZE on snooze; snz_cnt cleared.
  - SNOOZE: snz_cnt++ on each sec_tick. At snz_cnt==SNOOZE_MINS*60-1 plus a tick -> RINGING; ring_cnt cleared.
  - RINGING or SNOOZE -> IDLE on stop. stop wins over a simultaneous snooze.
  - Any state -> IDLE when alarm_en=0 or alarm_set=1. This has highest priority after reset.
  - snooze in IDLE or SNOOZE is ignored. stop in IDLE is ignored.
- Latency:
  - ringing rises on the cycle after the trigger condition.
  - ringing falls on the cycle after the stop, snooze, or timeout cycle.
- Widths: snz_cnt is sized as clog2(SNOOZE_MINS*60), 10 bits max. ring_cnt is 6 bits.
- Inputs are assumed synchronous to clk. Out-of-range sec/min/hour values never match (alarm fields are always in range).

Decomposition:
- Shared package:
  - state typedef/localparams IDLE/RINGING/SNOOZE.
  - MAX_SEC=59, MAX_MIN=59, MAX_HOUR=23.
  - SECS_PER_MIN=60.
- Sub-module sec_tick_detect: registers sec, outputs a one-cycle sec_tick on change, resets to sec_prev=0.

Test Plan:
- Reset with clear=1 -> alarm_min=0, alarm_hour=7, ringing=0, state=0. After release, with alarm_set=0, pulse adj_min -> alarm_min stays 0.
- alarm_set=1: 60 adj_min pulses -> alarm_min 0..59 then 0. 24 adj_hour pulses from 7 -> wraps 23->0 and ends at 7. Simultaneous adj_min+adj_hour -> both increment.
- alarm_en=1, alarm 07:00. Drive time 06:59:59 -> 07:00:00 -> ringing=1 next cycle. Advance 30 sec values -> ringing=0, state=IDLE. Holding sec=0 for many cycles does not retrigger.
- While RINGING, pulse snooze -> state=SNOOZE, ringing=0. Advance 300 sec ticks -> ringing=1 exactly after the 300th tick.
- In RINGING, pulse snooze and stop in the same cycle -> state=IDLE. In SNOOZE, drop alarm_en -> IDLE.
- Assert clear mid-RINGING -> ringing=0 immediately (async). The alarm time returns to 07:00.
